regfile_master: RTL and testbench
=================================

// Module: regfile_master
// PURPOSE
//  Command-driven initiator that owns the clk/we3/ra1/ra2/wa3/wd3 port set of the 3-port regfile.
//  Accepts WRITE, READ-pair, CLEAR-all and COPY commands on a valid/ready channel.
//  Sequences the regfile accesses and returns one response per command on a second valid/ready channel.
//  The regfile is assumed to have combinational read (rd1/rd2) and to write on posedge clk when we3=1.
// PARAMETERS
//  DATA_W  32  regfile word width
//  ADDR_W   5  regfile address width
//  NREGS   32  number of implemented registers (<= 2**ADDR_W)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       master can accept a command
//  cmd_op      in   2       00 WRITE, 01 READ, 10 CLEAR, 11 COPY
//  cmd_addr_a  in   ADDR_W  WRITE dest / READ port-1 addr / COPY source
//  cmd_addr_b  in   ADDR_W  READ port-2 addr / COPY dest
//  cmd_wdata   in   DATA_W  WRITE data
//  rsp_valid   out  1       response present
//  rsp_ready   in   1       consumer accepts response
//  rsp_data_a  out  DATA_W  READ: rd1 value; COPY: copied value; else 0
//  rsp_data_b  out  DATA_W  READ: rd2 value; else 0
//  rsp_err     out  1       command rejected (address >= NREGS)
//  busy        out  1       state != IDLE
//  rf_ra1      out  ADDR_W  regfile read address 1
//  rf_ra2      out  ADDR_W  regfile read address 2
//  rf_wa3      out  ADDR_W  regfile write address
//  rf_wd3      out  DATA_W  regfile write data
//  rf_we3      out  1       regfile write enable
//  rf_rd1      in   DATA_W  regfile read data 1
//  rf_rd2      in   DATA_W  regfile read data 2
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   state=IDLE; cmd_ready=1; rsp_valid=0; rsp_err=0; all rf_* outputs=0.
//   rsp_data_a/b=0; CLEAR counter=0.
//   Reset mid-command aborts it immediately; writes already committed remain, no response is produced.
//  States: IDLE, WRITE, READ, CLEAR, COPY_RD, COPY_WR, RESP.
//   All outputs are registered or decoded from registered state only.
//   cmd_ready = (state==IDLE); busy = !cmd_ready.
//  Accept: on the edge with cmd_valid & cmd_ready, latch op/addresses/wdata.
//   If any used address >= NREGS: go to RESP with rsp_err=1 and data=0; no regfile access occurs.
//   Used addresses: WRITE a; READ a,b; COPY a,b; CLEAR none.
//  WRITE: 1 cycle, rf_we3=1, rf_wa3=a, rf_wd3=wdata -> RESP. Data fields are 0.
//  READ: 1 cycle, rf_ra1=a, rf_ra2=b; capture rf_rd1/rf_rd2 at the closing edge -> RESP.
//  CLEAR: NREGS cycles, rf_we3=1, rf_wd3=0, rf_wa3=counter 0..NREGS-1 -> RESP.
//   Counter is cleared on exit.
//  COPY_RD: 1 cycle, rf_ra1=a; capture rf_rd1 into tmp -> COPY_WR.
//  COPY_WR: 1 cycle, rf_we3=1, rf_wa3=b, rf_wd3=tmp -> RESP with rsp_data_a=tmp.
//   a==b is legal and rewrites the same value.
//  Latency (accept edge to rsp_valid high):
//   WRITE/READ 2 cycles; COPY 3; CLEAR NREGS+1; error 1.
//  RESP: rsp_valid=1; data/err held stable until rsp_valid & rsp_ready.
//   On that edge: rsp_valid=0 -> IDLE.
//   A new command is accepted no earlier than the following edge, so at most one command is outstanding.
//  rf_we3 is 0 in IDLE, READ, COPY_RD and RESP. No special-casing of register 0.
//   Register-0 semantics belong to the regfile.
//  cmd_valid while busy is ignored; no command is latched, so the initiator must hold it until accepted.
// TESTING
//  1. WRITE a=0 wdata=A5A5A5A5, then WRITE a=1 wdata=5A5A5A5A -> two responses, err=0.
//     rf_we3 high exactly one cycle each.
//  2. READ a=0 b=1 -> rsp_data_a=A5A5A5A5, rsp_data_b=5A5A5A5A, rsp_valid 2 cycles after accept.
//  3. COPY a=1 b=7, then READ a=7 b=0 -> COPY rsp_data_a=5A5A5A5A.
//     READ returns 5A5A5A5A / A5A5A5A5.
//  4. Hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid and data stable; cmd_ready stays 0.
//     Then pulse rsp_ready -> IDLE on the next cycle.
//  5. CLEAR with NREGS=32 -> 32 consecutive we3 cycles, wa3 0..31.
//     A following READ a=0 b=1 returns 0/0.
//  6. With NREGS=16, WRITE a=20 -> rsp_err=1 after 1 cycle, rf_we3 never asserted.
//     Also: assert rst_n=0 mid-CLEAR at count 10 -> rf_we3=0 immediately, state IDLE.
//     Regs 0..9 are 0; later regs are unchanged.

Source files
------------

// File: rtl/regfile_master.sv
// Command-driven initiator for a 3-port regfile (2 combinational reads, 1 clocked write).
// Sequences WRITE / READ / CLEAR / COPY commands and returns one response per command.
module regfile_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    output logic [ADDR_W-1:0] rf_wa3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              rf_we3,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2
);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_COPY  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_CLEAR, S_COPY_RD, S_COPY_WR, S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_tmp;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_rsp_a;
    logic [DATA_W-1:0] r_rsp_b;
    logic              r_rsp_err;

    logic w_bad_a;
    logic w_bad_b;
    logic w_cmd_bad;
    logic w_accept;
    logic w_clr_last;

    assign w_bad_a    = 32'(cmd_addr_a) >= 32'(NREGS);
    assign w_bad_b    = 32'(cmd_addr_b) >= 32'(NREGS);
    // CLEAR touches no caller-supplied address, so it can never be rejected.
    assign w_cmd_bad  = (cmd_op == OP_WRITE) ? w_bad_a :
                        (cmd_op == OP_CLEAR) ? 1'b0    : (w_bad_a | w_bad_b);
    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_clr_last = 32'(r_cnt) == 32'(NREGS - 1);

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = !cmd_ready;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_data_a = r_rsp_a;
    assign rsp_data_b = r_rsp_b;
    assign rsp_err    = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_next = r_state;
        rf_we3 = 1'b0;
        rf_wa3 = '0;
        rf_wd3 = '0;
        rf_ra1 = '0;
        rf_ra2 = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_cmd_bad) w_next = S_RESP;
                    else begin
                        case (op_t'(cmd_op))
                            OP_WRITE: w_next = S_WRITE;
                            OP_READ:  w_next = S_READ;
                            OP_CLEAR: w_next = S_CLEAR;
                            default:  w_next = S_COPY_RD;
                        endcase
                    end
                end
            end
            S_WRITE: begin
                rf_we3 = 1'b1;
                rf_wa3 = r_addr_a;
                rf_wd3 = r_wdata;
                w_next = S_RESP;
            end
            S_READ: begin
                rf_ra1 = r_addr_a;
                rf_ra2 = r_addr_b;
                w_next = S_RESP;
            end
            S_CLEAR: begin
                rf_we3 = 1'b1;
                rf_wa3 = r_cnt;
                if (w_clr_last) w_next = S_RESP;
            end
            S_COPY_RD: begin
                rf_ra1 = r_addr_a;
                w_next = S_COPY_WR;
            end
            S_COPY_WR: begin
                rf_we3 = 1'b1;
                rf_wa3 = r_addr_b;
                rf_wd3 = r_tmp;
                w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_wdata   <= '0;
            r_tmp     <= '0;
            r_cnt     <= '0;
            r_rsp_a   <= '0;
            r_rsp_b   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr_a  <= cmd_addr_a;
                        r_addr_b  <= cmd_addr_b;
                        r_wdata   <= cmd_wdata;
                        r_rsp_a   <= '0;
                        r_rsp_b   <= '0;
                        r_rsp_err <= w_cmd_bad;
                    end
                end
                S_READ: begin
                    r_rsp_a <= rf_rd1;
                    r_rsp_b <= rf_rd2;
                end
                S_CLEAR:   r_cnt   <= w_clr_last ? '0 : r_cnt + 1'b1;
                S_COPY_RD: r_tmp   <= rf_rd1;
                S_COPY_WR: r_rsp_a <= r_tmp;
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_a   <= '0;
                        r_rsp_b   <= '0;
                        r_rsp_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_master.sv
// Bench for regfile_master: two instances (NREGS=32 and NREGS=16) each driving a behavioural regfile,
// checked against a command-level reference model plus literal expectations.
module tb_regfile_master;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_CL = 2'b10;
    localparam logic [1:0] OP_CP = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    logic rf_init;
    logic sel;
    logic cmd_v;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr_a, cmd_addr_b;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_ready;

    logic          cr0, rv0, err0, busy0, we0;
    logic [DW-1:0] da0, db0, wd0, rd1_0, rd2_0;
    logic [AW-1:0] ra1_0, ra2_0, wa0;
    logic          cr1, rv1, err1, busy1, we1;
    logic [DW-1:0] da1, db1, wd1, rd1_1, rd2_1;
    logic [AW-1:0] ra1_1, ra2_1, wa1;

    logic [DW-1:0] rf0 [32];
    logic [DW-1:0] rf1 [32];
    logic [DW-1:0] ref_mem [2][32];

    logic          m_cr, m_rv, m_err, m_busy, m_we;
    logic [DW-1:0] m_da, m_db, m_wd;
    logic [AW-1:0] m_wa, m_ra1, m_ra2;

    logic [36:0]   exp_wq[$];
    logic          exp_err;
    logic [DW-1:0] exp_a, exp_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_master #(.DATA_W(DW), .ADDR_W(AW), .NREGS(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_v && !sel), .cmd_ready(cr0),
        .cmd_op(cmd_op), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv0), .rsp_ready(rsp_ready && !sel), .rsp_data_a(da0), .rsp_data_b(db0),
        .rsp_err(err0), .busy(busy0), .rf_ra1(ra1_0), .rf_ra2(ra2_0), .rf_wa3(wa0),
        .rf_wd3(wd0), .rf_we3(we0), .rf_rd1(rd1_0), .rf_rd2(rd2_0)
    );

    regfile_master #(.DATA_W(DW), .ADDR_W(AW), .NREGS(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_v && sel), .cmd_ready(cr1),
        .cmd_op(cmd_op), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready && sel), .rsp_data_a(da1), .rsp_data_b(db1),
        .rsp_err(err1), .busy(busy1), .rf_ra1(ra1_1), .rf_ra2(ra2_1), .rf_wa3(wa1),
        .rf_wd3(wd1), .rf_we3(we1), .rf_rd1(rd1_1), .rf_rd2(rd2_1)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hC0DE_0000 + DW'(i);
    endfunction

    // Behavioural regfiles: combinational read, write on rising edge.
    assign rd1_0 = rf0[ra1_0];
    assign rd2_0 = rf0[ra2_0];
    assign rd1_1 = rf1[ra1_1];
    assign rd2_1 = rf1[ra2_1];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) begin
                rf0[i] <= init_val(i);
                rf1[i] <= init_val(i);
            end
        end else begin
            if (we0) rf0[wa0] <= wd0;
            if (we1) rf1[wa1] <= wd1;
        end
    end

    assign m_cr   = sel ? cr1   : cr0;
    assign m_rv   = sel ? rv1   : rv0;
    assign m_err  = sel ? err1  : err0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_we   = sel ? we1   : we0;
    assign m_da   = sel ? da1   : da0;
    assign m_db   = sel ? db1   : db0;
    assign m_wd   = sel ? wd1   : wd0;
    assign m_wa   = sel ? wa1   : wa0;
    assign m_ra1  = sel ? ra1_1 : ra1_0;
    assign m_ra2  = sel ? ra2_1 : ra2_0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle compare: every regfile write must be the next one the model predicts,
    // and a presented response must match the model's response for the outstanding command.
    always @(negedge clk) begin : compare
        logic [36:0] w;
        if (rst_n && m_we) begin
            check("write_expected", m_we, exp_wq.size() > 0);
            if (exp_wq.size() > 0) begin
                w = exp_wq.pop_front();
                check("write_addr_data", {m_wa, m_wd}, w);
            end
        end
        if (rst_n && m_rv) check("rsp_fields", {m_err, m_da, m_db}, {exp_err, exp_a, exp_b});
    end

    task automatic issue(input logic [1:0] op, input int a, input int b, input logic [DW-1:0] wd,
                         input int hold, output logic [DW-1:0] ga, output logic [DW-1:0] gb,
                         output logic ge, output int lat_got);
        int n;
        int lat;
        int nr;
        int s;
        s  = sel ? 1 : 0;
        nr = sel ? 16 : 32;
        exp_err = ((op == OP_WR) && a >= nr) || ((op == OP_RD || op == OP_CP) && (a >= nr || b >= nr));
        exp_a = '0;
        exp_b = '0;
        if (exp_err) lat = 1;
        else begin
            case (op)
                OP_WR: begin
                    lat = 2;
                    exp_wq.push_back({a[4:0], wd});
                    ref_mem[s][a] = wd;
                end
                OP_RD: begin
                    lat = 2;
                    exp_a = ref_mem[s][a];
                    exp_b = ref_mem[s][b];
                end
                OP_CP: begin
                    lat = 3;
                    exp_a = ref_mem[s][a];
                    exp_wq.push_back({b[4:0], ref_mem[s][a]});
                    ref_mem[s][b] = ref_mem[s][a];
                end
                default: begin
                    lat = nr + 1;
                    for (int i = 0; i < nr; i++) begin
                        exp_wq.push_back({i[4:0], 32'h0});
                        ref_mem[s][i] = '0;
                    end
                end
            endcase
        end
        @(negedge clk);
        cmd_op = op; cmd_addr_a = a[4:0]; cmd_addr_b = b[4:0]; cmd_wdata = wd;
        cmd_v = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!m_cr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", m_cr, 1'b1);
        @(posedge clk);
        #1 cmd_v = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_rv && n < 100);
        lat_got = n;
        check("latency", n, lat);
        ga = m_da; gb = m_db; ge = m_err;
        for (int k = 0; k < hold; k++) begin
            check("hold_not_ready", m_cr, 1'b0);
            check("hold_valid", m_rv, 1'b1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_released", m_rv, 1'b0);
        check("back_idle", m_cr, 1'b1);
        check("writes_done", exp_wq.size(), 0);
    endtask

    logic [DW-1:0] ga, gb;
    logic          ge;
    int            lg;
    int            n;

    initial begin
        rst_n = 1'b0; rf_init = 1'b1; sel = 1'b0; cmd_v = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[0][i] = init_val(i);
            ref_mem[1][i] = init_val(i);
        end
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cr0, 1'b1);
        check("rst_rsp_valid", rv0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_rf_outs", {we0, wa0, wd0, ra1_0, ra2_0}, '0);
        check("rst_rsp_data", {err0, da0, db0}, '0);
        check("rst_dut1_idle", {cr1, rv1, we1}, 3'b100);
        rf_init = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // Writes, read-back and copies on the 32-register instance.
        issue(OP_WR, 0, 0, 32'hA5A5_A5A5, 0, ga, gb, ge, lg);
        check("wr0_err", ge, 1'b0);
        issue(OP_WR, 1, 0, 32'h5A5A_5A5A, 0, ga, gb, ge, lg);
        check("wr1_err", ge, 1'b0);
        issue(OP_RD, 0, 1, 32'h0, 0, ga, gb, ge, lg);
        check("rd01", {ge, ga, gb}, {1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A});
        check("rd_lat", lg, 2);
        issue(OP_CP, 1, 7, 32'h0, 0, ga, gb, ge, lg);
        check("cp17", {ge, ga, gb}, {1'b0, 32'h5A5A_5A5A, 32'h0});
        check("cp_lat", lg, 3);
        issue(OP_RD, 7, 0, 32'h0, 0, ga, gb, ge, lg);
        check("rd70", {ga, gb}, {32'h5A5A_5A5A, 32'hA5A5_A5A5});
        issue(OP_CP, 0, 0, 32'h0, 0, ga, gb, ge, lg);
        check("cp_self", ga, 32'hA5A5_A5A5);
        issue(OP_RD, 3, 31, 32'h0, 5, ga, gb, ge, lg);
        check("rd_hold", {ga, gb}, {32'hC0DE_0003, 32'hC0DE_001F});

        issue(OP_CL, 0, 0, 32'h0, 0, ga, gb, ge, lg);
        check("clr_lat", lg, 33);
        issue(OP_RD, 0, 1, 32'h0, 0, ga, gb, ge, lg);
        check("rd_after_clr", {ga, gb}, 64'h0);

        // Address range checks on the 16-register instance.
        sel = 1'b1;
        @(negedge clk);
        issue(OP_WR, 20, 0, 32'hDEAD_BEEF, 0, ga, gb, ge, lg);
        check("wr20_err", {ge, ga, gb}, {1'b1, 64'h0});
        check("err_lat", lg, 1);
        issue(OP_RD, 3, 16, 32'h0, 0, ga, gb, ge, lg);
        check("rd_b16_err", ge, 1'b1);
        issue(OP_CP, 17, 2, 32'h0, 0, ga, gb, ge, lg);
        check("cp_a17_err", ge, 1'b1);
        issue(OP_WR, 15, 0, 32'h1515_1515, 0, ga, gb, ge, lg);
        check("wr15_ok", ge, 1'b0);
        issue(OP_RD, 15, 2, 32'h0, 0, ga, gb, ge, lg);
        check("rd15", {ge, ga, gb}, {1'b0, 32'h1515_1515, 32'hC0DE_0002});
        issue(OP_CL, 0, 0, 32'h0, 0, ga, gb, ge, lg);
        check("clr16_lat", lg, 17);
        issue(OP_RD, 15, 0, 32'h0, 0, ga, gb, ge, lg);
        check("rd_after_clr16", {ga, gb}, 64'h0);
        sel = 1'b0;
        @(negedge clk);

        // Reset in the middle of CLEAR on the 32-register instance.
        issue(OP_WR, 9,  0, 32'h0000_0099, 0, ga, gb, ge, lg);
        issue(OP_WR, 10, 0, 32'h0000_1010, 0, ga, gb, ge, lg);
        issue(OP_WR, 31, 0, 32'h0000_3131, 0, ga, gb, ge, lg);
        for (int i = 0; i < 32; i++) exp_wq.push_back({i[4:0], 32'h0});
        @(negedge clk);
        cmd_op = OP_CL; cmd_v = 1'b1;
        @(posedge clk);
        #1 cmd_v = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wa0 != 5'd10 && n < 50);
        check("clr_reach_10", wa0, 5'd10);
        check("clr_we_at_10", we0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_we_low", we0, 1'b0);
        check("abort_idle", {cr0, busy0, rv0}, 3'b100);
        for (int i = 0; i < 10; i++) ref_mem[0][i] = '0;
        exp_wq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_RD, 9, 10, 32'h0, 0, ga, gb, ge, lg);
        check("abort_rd_9_10", {ga, gb}, {32'h0, 32'h0000_1010});
        issue(OP_RD, 31, 0, 32'h0, 0, ga, gb, ge, lg);
        check("abort_rd_31_0", {ga, gb}, {32'h0000_3131, 32'h0});

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
